clint_trap_ctrl: RTL and testbench



---
 rtl/clint_pkg.sv | 37 +++
 rtl/clint_trap_ctrl.sv | 167 ++++++++++++++++
 tb/tb_clint_trap_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// Shared types and constants for the machine-mode trap sequencer (clint_trap_ctrl).
package clint_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_W_MEPC,
      S_W_MSTATUS,
      S_W_MCAUSE,
      S_R_MSTATUS,
      S_JUMP
   } state_t;

   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   // Trap entry stashes MIE into MPIE and disables interrupts.
   function automatic logic [31:0] trapMstatus(input logic [31:0] ms);
      logic [31:0] r;
      r               = ms;
      r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
      r[MSTATUS_MIE]  = 1'b0;
      return r;
   endfunction

   function automatic logic [31:0] mretMstatus(input logic [31:0] ms);
      logic [31:0] r;
      r               = ms;
      r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/clint_trap_ctrl.sv
// Trap sequencer: writes mepc/mstatus/mcause through the CSR file's clint port, then redirects fetch.
// Optional machine timer interrupt input is enabled by defining CLINT_TIMER_IRQ_EN.
module clint_trap_ctrl
   import clint_pkg::*;
#(
   parameter logic [31:0] CAUSE_ECALL   = 32'd11,
   parameter logic [31:0] CAUSE_EBREAK  = 32'd3,
   parameter logic [31:0] CAUSE_EXT_IRQ = 32'h8000_000B
`ifdef CLINT_TIMER_IRQ_EN
   ,
   parameter logic [31:0] CAUSE_TIMER_IRQ = 32'h8000_0007
`endif
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ecall_i,
   input  logic        ebreak_i,
   input  logic        mret_i,
   input  logic        irq_ext_i,
`ifdef CLINT_TIMER_IRQ_EN
   input  logic        irq_timer_i,
`endif
   input  logic [31:0] inst_addr_i,
   input  logic [31:0] next_pc_i,
   input  logic        ex_csr_wen_i,
   output logic        clint_wen_o,
   output logic [31:0] clint_waddr_o,
   output logic [31:0] clint_wdata_o,
   input  logic [31:0] csr_mtvec_i,
   input  logic [31:0] csr_mepc_i,
   input  logic [31:0] csr_mstatus_i,
   output logic        hold_o,
   output logic        jump_o,
   output logic [31:0] jump_addr_o
);

   state_t      r_state;
   logic [31:0] r_epc;
   logic [31:0] r_cause;
   logic [31:0] r_jumpAddr;

   logic w_mie;
   logic w_extTaken;
   logic w_timerTaken;
   logic w_eventTaken;

   assign w_mie      = csr_mstatus_i[MSTATUS_MIE];
   assign w_extTaken = irq_ext_i & w_mie;
`ifdef CLINT_TIMER_IRQ_EN
   assign w_timerTaken = irq_timer_i & w_mie;
`else
   assign w_timerTaken = 1'b0;
`endif
   assign w_eventTaken = ecall_i | ebreak_i | mret_i | w_extTaken | w_timerTaken;

   // A write state only advances once EX is not claiming the CSR write port.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_epc      <= 32'h0;
         r_cause    <= 32'h0;
         r_jumpAddr <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ecall_i) begin
                  r_epc   <= inst_addr_i;
                  r_cause <= CAUSE_ECALL;
                  r_state <= S_W_MEPC;
               end else if (ebreak_i) begin
                  r_epc   <= inst_addr_i;
                  r_cause <= CAUSE_EBREAK;
                  r_state <= S_W_MEPC;
               end else if (mret_i) begin
                  r_state <= S_R_MSTATUS;
               end else if (w_extTaken) begin
                  r_epc   <= next_pc_i;
                  r_cause <= CAUSE_EXT_IRQ;
                  r_state <= S_W_MEPC;
`ifdef CLINT_TIMER_IRQ_EN
               end else if (w_timerTaken) begin
                  r_epc   <= next_pc_i;
                  r_cause <= CAUSE_TIMER_IRQ;
                  r_state <= S_W_MEPC;
`endif
               end
            end
            S_W_MEPC: begin
               if (!ex_csr_wen_i) begin
                  r_state <= S_W_MSTATUS;
               end
            end
            S_W_MSTATUS: begin
               if (!ex_csr_wen_i) begin
                  r_state <= S_W_MCAUSE;
               end
            end
            S_W_MCAUSE: begin
               if (!ex_csr_wen_i) begin
                  r_jumpAddr <= csr_mtvec_i & ~32'h3;
                  r_state    <= S_JUMP;
               end
            end
            S_R_MSTATUS: begin
               if (!ex_csr_wen_i) begin
                  r_jumpAddr <= csr_mepc_i;
                  r_state    <= S_JUMP;
               end
            end
            S_JUMP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs decode from state; hold rises combinationally on the detect cycle.
   always_comb begin
      clint_wen_o   = 1'b0;
      clint_waddr_o = 32'h0;
      clint_wdata_o = 32'h0;
      hold_o        = 1'b0;
      jump_o        = 1'b0;
      jump_addr_o   = 32'h0;
      case (r_state)
         S_IDLE: begin
            hold_o = w_eventTaken;
         end
         S_W_MEPC: begin
            hold_o        = 1'b1;
            clint_wen_o   = 1'b1;
            clint_waddr_o = {20'h0, CSR_MEPC};
            clint_wdata_o = r_epc;
         end
         S_W_MSTATUS: begin
            hold_o        = 1'b1;
            clint_wen_o   = 1'b1;
            clint_waddr_o = {20'h0, CSR_MSTATUS};
            clint_wdata_o = trapMstatus(csr_mstatus_i);
         end
         S_W_MCAUSE: begin
            hold_o        = 1'b1;
            clint_wen_o   = 1'b1;
            clint_waddr_o = {20'h0, CSR_MCAUSE};
            clint_wdata_o = r_cause;
         end
         S_R_MSTATUS: begin
            hold_o        = 1'b1;
            clint_wen_o   = 1'b1;
            clint_waddr_o = {20'h0, CSR_MSTATUS};
            clint_wdata_o = mretMstatus(csr_mstatus_i);
         end
         S_JUMP: begin
            hold_o      = 1'b1;
            jump_o      = 1'b1;
            jump_addr_o = r_jumpAddr;
         end
         default: begin
            hold_o = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Directed self-checking bench for clint_trap_ctrl; each scenario walks a table of expected per-cycle outputs.
module tb_clint_trap_ctrl;

   logic        clk;
   logic        rst;
   logic        ecall;
   logic        ebreak;
   logic        mret;
   logic        irqExt;
`ifdef CLINT_TIMER_IRQ_EN
   logic        irqTimer;
`endif
   logic [31:0] instAddr;
   logic [31:0] nextPc;
   logic        exCsrWen;
   logic        wen;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic [31:0] mstatus;
   logic        hold;
   logic        jump;
   logic [31:0] jumpAddr;

   int checks;
   int errors;

   clint_trap_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .ecall_i       (ecall),
      .ebreak_i      (ebreak),
      .mret_i        (mret),
      .irq_ext_i     (irqExt),
`ifdef CLINT_TIMER_IRQ_EN
      .irq_timer_i   (irqTimer),
`endif
      .inst_addr_i   (instAddr),
      .next_pc_i     (nextPc),
      .ex_csr_wen_i  (exCsrWen),
      .clint_wen_o   (wen),
      .clint_waddr_o (waddr),
      .clint_wdata_o (wdata),
      .csr_mtvec_i   (mtvec),
      .csr_mepc_i    (mepc),
      .csr_mstatus_i (mstatus),
      .hold_o        (hold),
      .jump_o        (jump),
      .jump_addr_o   (jumpAddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output bundle: {hold, jump, wen, waddr, wdata, jumpAddr}
   function automatic logic [98:0] snap();
      return {hold, jump, wen, waddr, wdata, jumpAddr};
   endfunction

   function automatic logic [98:0] pack(input logic h, input logic j, input logic w,
                                        input logic [31:0] a, input logic [31:0] d,
                                        input logic [31:0] ja);
      return {h, j, w, a, d, ja};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (snap() !== 99'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h want %h", snap(), 99'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (snap() !== 99'h0) begin
         errors++;
         $display("[TB] FAIL reset_release: got %h want %h", snap(), 99'h0);
      end
   endtask

   task automatic test_ecall();
      logic [98:0] expv [6];
      expv = '{pack(1, 0, 0, 32'h0,   32'h0,   32'h0),
               pack(1, 0, 1, 32'h341, 32'h100, 32'h0),
               pack(1, 0, 1, 32'h300, 32'h80,  32'h0),
               pack(1, 0, 1, 32'h342, 32'd11,  32'h0),
               pack(1, 1, 0, 32'h0,   32'h0,   32'h2000),
               pack(0, 0, 0, 32'h0,   32'h0,   32'h0)};
      instAddr = 32'h100;
      mtvec    = 32'h2001;
      mstatus  = 32'h8;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ecall = (i == 0);
         #1;
         checks++;
         if (snap() !== expv[i]) begin
            errors++;
            $display("[TB] FAIL ecall[%0d]: got %h want %h", i, snap(), expv[i]);
         end
      end
   endtask

   task automatic test_irq();
      logic [98:0] expv [8];
      expv = '{pack(0, 0, 0, 32'h0,   32'h0,          32'h0),
               pack(0, 0, 0, 32'h0,   32'h0,          32'h0),
               pack(1, 0, 0, 32'h0,   32'h0,          32'h0),
               pack(1, 0, 1, 32'h341, 32'h200,        32'h0),
               pack(1, 0, 1, 32'h300, 32'h80,         32'h0),
               pack(1, 0, 1, 32'h342, 32'h8000_000B,  32'h0),
               pack(1, 1, 0, 32'h0,   32'h0,          32'h2000),
               pack(0, 0, 0, 32'h0,   32'h0,          32'h0)};
      instAddr = 32'h1FC;
      nextPc   = 32'h200;
      mtvec    = 32'h2001;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         irqExt  = (i <= 2);
         mstatus = (i < 2) ? 32'h0 : 32'h8;
         #1;
         checks++;
         if (snap() !== expv[i]) begin
            errors++;
            $display("[TB] FAIL irq[%0d]: got %h want %h", i, snap(), expv[i]);
         end
      end
   endtask

   task automatic test_stall();
      logic [98:0] expv [8];
      expv = '{pack(1, 0, 0, 32'h0,   32'h0,   32'h0),
               pack(1, 0, 1, 32'h341, 32'h100, 32'h0),
               pack(1, 0, 1, 32'h300, 32'h80,  32'h0),
               pack(1, 0, 1, 32'h300, 32'h80,  32'h0),
               pack(1, 0, 1, 32'h300, 32'h80,  32'h0),
               pack(1, 0, 1, 32'h342, 32'd11,  32'h0),
               pack(1, 1, 0, 32'h0,   32'h0,   32'h2000),
               pack(0, 0, 0, 32'h0,   32'h0,   32'h0)};
      instAddr = 32'h100;
      mtvec    = 32'h2001;
      mstatus  = 32'h8;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ecall    = (i == 0);
         exCsrWen = (i == 2) || (i == 3);
         #1;
         checks++;
         if (snap() !== expv[i]) begin
            errors++;
            $display("[TB] FAIL stall[%0d]: got %h want %h", i, snap(), expv[i]);
         end
      end
   endtask

   task automatic test_ebreak();
      logic [98:0] expv [6];
      expv = '{pack(1, 0, 0, 32'h0,   32'h0,    32'h0),
               pack(1, 0, 1, 32'h341, 32'h300,  32'h0),
               pack(1, 0, 1, 32'h300, 32'h1880, 32'h0),
               pack(1, 0, 1, 32'h342, 32'd3,    32'h0),
               pack(1, 1, 0, 32'h0,   32'h0,    32'h4000),
               pack(0, 0, 0, 32'h0,   32'h0,    32'h0)};
      instAddr = 32'h300;
      mtvec    = 32'h4003;
      mstatus  = 32'h1808;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ebreak = (i == 0);
         mret   = (i == 0) || (i == 2);
         #1;
         checks++;
         if (snap() !== expv[i]) begin
            errors++;
            $display("[TB] FAIL ebreak[%0d]: got %h want %h", i, snap(), expv[i]);
         end
      end
   endtask

   task automatic test_mret();
      logic [98:0] expv [8];
      expv = '{pack(1, 0, 0, 32'h0,   32'h0,    32'h0),
               pack(1, 0, 1, 32'h300, 32'h88,   32'h0),
               pack(1, 1, 0, 32'h0,   32'h0,    32'h104),
               pack(0, 0, 0, 32'h0,   32'h0,    32'h0),
               pack(1, 0, 0, 32'h0,   32'h0,    32'h0),
               pack(1, 0, 1, 32'h300, 32'h1880, 32'h0),
               pack(1, 1, 0, 32'h0,   32'h0,    32'h500),
               pack(0, 0, 0, 32'h0,   32'h0,    32'h0)};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         mret    = (i == 0) || (i == 4);
         mepc    = (i < 4) ? 32'h104 : 32'h500;
         mstatus = (i < 4) ? 32'h80 : 32'h1808;
         #1;
         checks++;
         if (snap() !== expv[i]) begin
            errors++;
            $display("[TB] FAIL mret[%0d]: got %h want %h", i, snap(), expv[i]);
         end
      end
   endtask

   task automatic test_priority_reset();
      logic [98:0] expv [4];
      expv = '{pack(1, 0, 0, 32'h0,   32'h0,   32'h0),
               pack(1, 0, 1, 32'h341, 32'h100, 32'h0),
               pack(1, 0, 1, 32'h300, 32'h80,  32'h0),
               pack(1, 0, 1, 32'h342, 32'd11,  32'h0)};
      instAddr = 32'h100;
      nextPc   = 32'h104;
      mtvec    = 32'h2001;
      mstatus  = 32'h8;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ecall  = (i == 0);
         mret   = (i == 0);
         irqExt = (i == 0);
         #1;
         checks++;
         if (snap() !== expv[i]) begin
            errors++;
            $display("[TB] FAIL prio[%0d]: got %h want %h", i, snap(), expv[i]);
         end
      end
      rst = 1'b1;
      #1;
      checks++;
      if (snap() !== 99'h0) begin
         errors++;
         $display("[TB] FAIL async_reset: got %h want %h", snap(), 99'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (snap() !== 99'h0) begin
         errors++;
         $display("[TB] FAIL reset_idle0: got %h want %h", snap(), 99'h0);
      end
      @(negedge clk);
      #1;
      checks++;
      if (snap() !== 99'h0) begin
         errors++;
         $display("[TB] FAIL reset_idle1: got %h want %h", snap(), 99'h0);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      ecall    = 1'b0;
      ebreak   = 1'b0;
      mret     = 1'b0;
      irqExt   = 1'b0;
`ifdef CLINT_TIMER_IRQ_EN
      irqTimer = 1'b0;
`endif
      instAddr = 32'h0;
      nextPc   = 32'h0;
      exCsrWen = 1'b0;
      mtvec    = 32'h0;
      mepc     = 32'h0;
      mstatus  = 32'h0;
      test_reset();
      test_ecall();
      test_irq();
      test_stall();
      test_ebreak();
      test_mret();
      test_priority_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
